// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and frame header format.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_HDR = 3'd1,
        ST_WAIT_HDR = 3'd2,
        ST_SEND_PAY = 3'd3,
        ST_WAIT_PAY = 3'd4
    } state_t;

    // Upper nibble of every header byte unless overridden at the top level.
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // Header byte layout: {tag[3:0], HDR_PAD[1:0], requester index[1:0]}.
    localparam logic [1:0] HDR_PAD = 2'b00;

    // Round-robin pointer after reset, so requester 0 is searched first.
    localparam logic [1:0] LAST_GRANT_RST = 2'd3;

    function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [1:0] idx);
        return {tag, HDR_PAD, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin selector: picks the first pending request after 'last'.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the grant.
//
// Ports:
//   req[3:0]      pending request flags
//   last[1:0]     index granted most recently; search starts at last+1 (mod 4)
//   gnt_valid     at least one request pending
//   gnt_idx[1:0]  selected requester (0 when gnt_valid is low)
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] cand;

    // Walk offsets from lowest priority (4 == last itself) to highest (1),
    // so the final hit is the nearest requester after 'last'.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Frame scheduler in front of a byte UART transmitter: grants one requester round-robin and sends {header, payload}.
// Latency: grant cycle -> header tx_start next cycle; payload tx_start one cycle after the header byte drains.
// Backpressure: waits for tx_busy to rise and fall per byte; never starts while tx_busy is high; one idle cycle between frames.
//
// Ports:
//   clk, reset       single rising-edge clock, synchronous active-high reset
//   req_valid[3:0]   per-requester byte pending
//   req_data[31:0]   requester i payload on [8i+7:8i]
//   req_ready[3:0]   one-cycle accept pulse to the granted requester
//   tx_start         start pulse to the UART transmitter
//   tx_data[7:0]     byte to the UART transmitter, held until the next send
//   tx_busy          busy flag from the UART transmitter
//   grant_id[1:0]    requester currently owning the link
//   sched_busy       high whenever a frame is in progress
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int         NUM_REQ = 4,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [1:0]           grant_id,
    output logic                 sched_busy
);

    state_t     state, state_nxt;
    logic [1:0] last_grant;
    logic       seen_busy;
    logic [7:0] pay;
    logic [1:0] grant;
    logic [7:0] tx_data_r;

    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [7:0] gnt_byte;
    logic       grant_take;
    logic       wait_exit;

    rr_arbiter4 u_arb (
        .req       (req_valid),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        gnt_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                gnt_byte = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and pulse outputs. SEND states also hold off on tx_busy so a
    // start can never overlap a transmission still in flight.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        tx_start   = 1'b0;
        grant_take = 1'b0;
        wait_exit  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gnt_valid && !tx_busy) begin
                    req_ready[gnt_idx] = 1'b1;
                    grant_take         = 1'b1;
                    state_nxt          = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = ST_WAIT_HDR;
                end
            end
            ST_WAIT_HDR: begin
                if (seen_busy && !tx_busy) begin
                    wait_exit = 1'b1;
                    state_nxt = ST_SEND_PAY;
                end
            end
            ST_SEND_PAY: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = ST_WAIT_PAY;
                end
            end
            ST_WAIT_PAY: begin
                if (seen_busy && !tx_busy) begin
                    wait_exit = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= LAST_GRANT_RST;
            seen_busy  <= 1'b0;
            pay        <= 8'h00;
            grant      <= 2'd0;
            tx_data_r  <= 8'h00;
        end else begin
            state <= state_nxt;

            // Payload and index are captured at grant so later changes on the
            // requester side cannot disturb the frame.
            if (grant_take) begin
                pay       <= gnt_byte;
                grant     <= gnt_idx;
                tx_data_r <= hdr_byte(HDR_TAG, gnt_idx);
            end

            if (state == ST_WAIT_HDR && wait_exit) begin
                tx_data_r <= pay;
            end

            if (state == ST_WAIT_HDR || state == ST_WAIT_PAY) begin
                if (wait_exit) begin
                    seen_busy <= 1'b0;
                end else if (tx_busy) begin
                    seen_busy <= 1'b1;
                end
            end

            if (state == ST_WAIT_PAY && wait_exit) begin
                last_grant <= grant;
            end
        end
    end

    assign tx_data    = tx_data_r;
    assign grant_id   = grant;
    assign sched_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed requests against a behavioural UART busy model,
// expected bytes/grants queued at stimulus time and checked by an independent monitor.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        sched_busy;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ (4),
        .HDR_TAG (4'hA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .sched_busy (sched_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_bytes[$];
    logic [3:0] exp_grants[$];

    int   busy_len   = 3;
    int   busy_cnt   = 0;
    logic prev_start = 1'b0;
    int   start_cnt  = 0;
    bit   drop_mode  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // UART transmitter model: samples tx_start on the rising edge, then reports
    // busy for busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) busy_cnt = 0;
            else if (prev_start) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy    = (busy_cnt != 0);
            prev_start = reset ? 1'b0 : tx_start;
        end
    end

    // Monitor: every start and every grant pulse is matched against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_start) begin
                    start_cnt++;
                    check("start_while_busy", {31'b0, tx_busy}, 32'd0);
                    if (exp_bytes.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_tx_start: got byte %0h expected none", tx_data);
                    end else begin
                        check("tx_byte", {24'b0, tx_data}, {24'b0, exp_bytes.pop_front()});
                    end
                end
                if (req_ready != 4'b0) begin
                    if (exp_grants.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_grant: got req_ready %0b expected none", req_ready);
                    end else begin
                        check("req_ready", {28'b0, req_ready}, {28'b0, exp_grants.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wait_grants(input int n);
        int seen = 0;
        int cyc  = 0;
        logic [3:0] g;
        while (seen < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            g = req_ready;
            if (g != 4'b0) begin
                seen++;
                if (drop_mode) begin
                    // Requester withdraws and trashes its data the cycle after acceptance.
                    @(posedge clk);
                    #1;
                    req_valid = req_valid & ~g;
                    for (int i = 0; i < 4; i++)
                        if (g[i]) req_data[8*i +: 8] = 8'hFF;
                end
            end
        end
        if (seen < n) timeout("wait_grants");
    endtask

    task automatic wait_idle();
        int cyc = 0;
        @(negedge clk);
        while (sched_busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (sched_busy) timeout("wait_idle");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int cyc;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start",   {31'b0, tx_start},   32'd0);
        check("rst_tx_data",    {24'b0, tx_data},    32'h00);
        check("rst_req_ready",  {28'b0, req_ready},  32'd0);
        check("rst_grant_id",   {30'b0, grant_id},   32'd0);
        check("rst_sched_busy", {31'b0, sched_busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request from requester 2
        busy_len  = 3;
        drop_mode = 1'b1;
        @(posedge clk);
        #1;
        req_data  = 32'h005C_0000;
        req_valid = 4'b0100;
        exp_grants.push_back(4'b0100);
        exp_bytes.push_back(8'hA2);
        exp_bytes.push_back(8'h5C);
        wait_grants(1);
        @(negedge clk);
        check("single_grant_id",   {30'b0, grant_id},   32'd2);
        check("single_sched_busy", {31'b0, sched_busy}, 32'd1);
        wait_idle();

        // All four requesting continuously from reset: order 0,1,2,3,0
        do_reset();
        drop_mode = 1'b0;
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        exp_grants.push_back(4'b0001); exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'h10);
        exp_grants.push_back(4'b0010); exp_bytes.push_back(8'hA1); exp_bytes.push_back(8'h11);
        exp_grants.push_back(4'b0100); exp_bytes.push_back(8'hA2); exp_bytes.push_back(8'h12);
        exp_grants.push_back(4'b1000); exp_bytes.push_back(8'hA3); exp_bytes.push_back(8'h13);
        exp_grants.push_back(4'b0001); exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'h10);
        wait_grants(5);
        @(posedge clk);
        #1;
        req_valid = 4'b0;
        wait_idle();

        // Long busy: requester 1, transmitter busy for 120 cycles per byte
        drop_mode = 1'b1;
        busy_len  = 120;
        base      = start_cnt;
        @(posedge clk);
        #1;
        req_data  = 32'h0000_3C00;
        req_valid = 4'b0010;
        exp_grants.push_back(4'b0010);
        exp_bytes.push_back(8'hA1);
        exp_bytes.push_back(8'h3C);
        wait_grants(1);
        wait_idle();
        check("long_busy_starts", start_cnt - base, 32'd2);

        // Reset in WAIT_PAY aborts the frame; then requester 0 beats 3
        busy_len = 20;
        base     = start_cnt;
        @(posedge clk);
        #1;
        req_data  = 32'h0077_0000;
        req_valid = 4'b0100;
        exp_grants.push_back(4'b0100);
        exp_bytes.push_back(8'hA2);
        exp_bytes.push_back(8'h77);
        wait_grants(1);
        cyc = 0;
        while (start_cnt < base + 2 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (start_cnt < base + 2) timeout("reach_wait_pay");
        @(posedge clk);
        #1;
        check("busy_before_reset", {31'b0, sched_busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx_start",   {31'b0, tx_start},   32'd0);
        check("abort_tx_data",    {24'b0, tx_data},    32'h00);
        check("abort_req_ready",  {28'b0, req_ready},  32'd0);
        check("abort_grant_id",   {30'b0, grant_id},   32'd0);
        check("abort_sched_busy", {31'b0, sched_busy}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        busy_len  = 3;
        req_data  = 32'h3300_0001;
        req_valid = 4'b1001;
        exp_grants.push_back(4'b0001); exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'h01);
        exp_grants.push_back(4'b1000); exp_bytes.push_back(8'hA3); exp_bytes.push_back(8'h33);
        wait_grants(2);
        wait_idle();

        // Requester 1 drops valid and corrupts data right after its grant
        @(posedge clk);
        #1;
        req_data  = 32'h0000_C400;
        req_valid = 4'b0010;
        exp_grants.push_back(4'b0010);
        exp_bytes.push_back(8'hA1);
        exp_bytes.push_back(8'hC4);
        wait_grants(1);
        wait_idle();
        repeat (5) @(negedge clk);

        check("leftover_bytes",  exp_bytes.size(),  32'd0);
        check("leftover_grants", exp_grants.size(), 32'd0);
        check("total_starts",    start_cnt,         32'd22);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
